// File: rtl/ex_dest_hazard_ctrl_if.sv
// ID/EX boundary bundle for the EX destination/hazard controller.
// The master drives the ID-stage instruction fields and flush; the slave
// (the controller) returns the EX dest select, stall/bubble and forwarding selects.
interface ex_dest_hazard_ctrl_if #(
  parameter int unsigned RW = 5
) ();
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic          id_regdst;
  logic          id_regwrite;
  logic          id_memread;
  logic          flush;
  logic          ex_sel;
  logic [RW-1:0] ex_dest;
  logic          stall;
  logic          bubble;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_regdst, id_regwrite, id_memread, flush,
    input  ex_sel, ex_dest, stall, bubble, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_regdst, id_regwrite, id_memread, flush,
    output ex_sel, ex_dest, stall, bubble, fwd_a, fwd_b
  );
endinterface

// File: rtl/ex_dest_hazard_ctrl.sv
// EX-stage destination-mux controller: latches the regdst select, tracks in-flight
// destinations through EX/MEM/WB, sequences load-use stalls and drives operand forwarding.
module ex_dest_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned RW       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  ex_dest_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e        r_state, w_state_d;
  logic [1:0]    r_cnt, w_cnt_d;

  // EX stage (dest lives in r_ex_dest, which is also the mux output)
  logic          r_ex_valid, r_ex_regwrite, r_ex_memread, r_ex_sel;
  logic [RW-1:0] r_ex_dest;
  // MEM and WB stages
  logic          r_mem_valid, r_mem_regwrite;
  logic [RW-1:0] r_mem_dest;
  logic          r_wb_valid, r_wb_regwrite;
  logic [RW-1:0] r_wb_dest;

  logic          r_bubble;
  logic [1:0]    r_fwd_a, r_fwd_b;

  logic [RW-1:0] w_id_dest;
  logic          w_hazard, w_stall, w_load_ex, w_ex_take;
  logic          w_ex_fwd_ok, w_mem_fwd_ok;
  logic [1:0]    w_fwd_a_d, w_fwd_b_d;

  assign w_id_dest = bus.id_regdst ? bus.id_rd : bus.id_rt;

  // Load in EX whose destination feeds the instruction now in ID
  assign w_hazard = bus.id_valid & r_ex_valid & r_ex_memread & r_ex_regwrite &
                    (r_ex_dest != '0) &
                    ((r_ex_dest == bus.id_rs) | (r_ex_dest == bus.id_rt));

  // FSM next state, stall and whether the ID instruction may enter EX
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_stall   = 1'b0;
    w_load_ex = 1'b0;
    if (bus.flush) begin
      w_state_d = StRun;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_hazard) begin
            w_stall = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_d = StStall;
              w_cnt_d   = 2'(LOAD_LAT - 1);
            end
          end else begin
            w_load_ex = 1'b1;
          end
        end
        StStall: begin
          w_stall = 1'b1;
          w_cnt_d = r_cnt - 2'd1;
          if (r_cnt == 2'd1) w_state_d = StRun;
        end
        default: w_state_d = StRun;
      endcase
    end
  end

  assign w_ex_take = w_load_ex & bus.id_valid;

  // Forwarding for the instruction entering EX: today's EX becomes its MEM, today's MEM its WB
  assign w_ex_fwd_ok  = r_ex_valid & r_ex_regwrite & (r_ex_dest != '0);
  assign w_mem_fwd_ok = r_mem_valid & r_mem_regwrite & (r_mem_dest != '0);

  // Per-operand forward select, MEM result beats WB result
  always_comb begin
    w_fwd_a_d = 2'b00;
    w_fwd_b_d = 2'b00;
    if (w_ex_fwd_ok && (r_ex_dest == bus.id_rs))        w_fwd_a_d = 2'b10;
    else if (w_mem_fwd_ok && (r_mem_dest == bus.id_rs)) w_fwd_a_d = 2'b01;
    if (w_ex_fwd_ok && (r_ex_dest == bus.id_rt))        w_fwd_b_d = 2'b10;
    else if (w_mem_fwd_ok && (r_mem_dest == bus.id_rt)) w_fwd_b_d = 2'b01;
  end

  // FSM state and stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StRun;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Pipeline stage registers; bubbles carry no regwrite/memread and no forwarding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid     <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_ex_sel       <= 1'b0;
      r_ex_dest      <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_dest     <= '0;
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_dest      <= '0;
      r_bubble       <= 1'b0;
      r_fwd_a        <= 2'b00;
      r_fwd_b        <= 2'b00;
    end else begin
      r_ex_valid     <= w_ex_take;
      r_ex_regwrite  <= w_ex_take & bus.id_regwrite;
      r_ex_memread   <= w_ex_take & bus.id_memread;
      r_ex_sel       <= bus.id_regdst;
      r_ex_dest      <= w_id_dest;
      r_mem_valid    <= r_ex_valid;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_dest     <= r_ex_dest;
      r_wb_valid     <= r_mem_valid;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_dest      <= r_mem_dest;
      r_bubble       <= ~w_ex_take;
      r_fwd_a        <= w_ex_take ? w_fwd_a_d : 2'b00;
      r_fwd_b        <= w_ex_take ? w_fwd_b_d : 2'b00;
    end
  end

  assign bus.ex_sel  = r_ex_sel;
  assign bus.ex_dest = r_ex_dest;
  assign bus.stall   = w_stall;
  assign bus.bubble  = r_bubble;
  assign bus.fwd_a   = r_fwd_a;
  assign bus.fwd_b   = r_fwd_b;

  // WB stage is tracked so the pipeline depth is explicit; only its valid/dest feed nothing yet
  logic w_wb_unused;
  assign w_wb_unused = ^{r_wb_valid, r_wb_regwrite, r_wb_dest};

endmodule

// File: tb/tb_ex_dest_hazard_ctrl.sv
// Bench for ex_dest_hazard_ctrl: one instance with LOAD_LAT=1 and one with LOAD_LAT=3.
// Stimulus pushes hand-computed expectations per cycle; a negedge monitor pops and compares.
module tb_ex_dest_hazard_ctrl;

  bit   clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  ex_dest_hazard_ctrl_if #(.RW(5)) bus1 ();
  ex_dest_hazard_ctrl_if #(.RW(5)) bus3 ();

  ex_dest_hazard_ctrl #(.LOAD_LAT(1), .RW(5)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  ex_dest_hazard_ctrl #(.LOAD_LAT(3), .RW(5)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  typedef struct {
    bit         d3;
    bit         stall;
    bit         bub;
    bit         c_ex;
    bit         sel;
    logic [4:0] dest;
    bit         c_fwd;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t  sb[$];
  string nq[$];
  int    n_total = 0;
  int    n_bad   = 0;

  task automatic chk(input string nm, input string f, input logic [7:0] act,
                     input logic [7:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s got=%0d want=%0d", nm, f, act, req);
    end
  endtask

  // Monitor: outputs sampled mid-cycle, away from the active edge
  exp_t  m_e;
  string m_nm;
  logic       a_stall, a_bub, a_sel;
  logic [4:0] a_dest;
  logic [1:0] a_fa, a_fb;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      m_e  = sb.pop_front();
      m_nm = nq.pop_front();
      if (m_e.d3) begin
        a_stall = bus3.stall; a_bub = bus3.bubble; a_sel = bus3.ex_sel;
        a_dest  = bus3.ex_dest; a_fa = bus3.fwd_a; a_fb = bus3.fwd_b;
      end else begin
        a_stall = bus1.stall; a_bub = bus1.bubble; a_sel = bus1.ex_sel;
        a_dest  = bus1.ex_dest; a_fa = bus1.fwd_a; a_fb = bus1.fwd_b;
      end
      chk(m_nm, "stall", {7'd0, a_stall}, {7'd0, m_e.stall});
      chk(m_nm, "bubble", {7'd0, a_bub}, {7'd0, m_e.bub});
      if (m_e.c_ex) begin
        chk(m_nm, "ex_sel", {7'd0, a_sel}, {7'd0, m_e.sel});
        chk(m_nm, "ex_dest", {3'd0, a_dest}, {3'd0, m_e.dest});
      end
      if (m_e.c_fwd) begin
        chk(m_nm, "fwd_a", {6'd0, a_fa}, {6'd0, m_e.fa});
        chk(m_nm, "fwd_b", {6'd0, a_fb}, {6'd0, m_e.fb});
      end
    end
  end

  // One cycle: drive ID inputs on the selected instance, queue expected outputs for this cycle
  task automatic cyc(input string nm, input bit d3, input bit rstv,
                     input bit v, input int rs, input int rt, input int rd,
                     input bit rdst, input bit rw, input bit mr, input bit fl,
                     input bit e_stall, input bit e_bub,
                     input bit c_ex, input bit e_sel, input int e_dest,
                     input bit c_fwd, input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    rst_n = rstv;
    bus1.id_valid = 1'b0; bus1.id_rs = '0; bus1.id_rt = '0; bus1.id_rd = '0;
    bus1.id_regdst = 1'b0; bus1.id_regwrite = 1'b0; bus1.id_memread = 1'b0; bus1.flush = 1'b0;
    bus3.id_valid = 1'b0; bus3.id_rs = '0; bus3.id_rt = '0; bus3.id_rd = '0;
    bus3.id_regdst = 1'b0; bus3.id_regwrite = 1'b0; bus3.id_memread = 1'b0; bus3.flush = 1'b0;
    if (d3) begin
      bus3.id_valid = v; bus3.id_rs = 5'(rs); bus3.id_rt = 5'(rt); bus3.id_rd = 5'(rd);
      bus3.id_regdst = rdst; bus3.id_regwrite = rw; bus3.id_memread = mr; bus3.flush = fl;
    end else begin
      bus1.id_valid = v; bus1.id_rs = 5'(rs); bus1.id_rt = 5'(rt); bus1.id_rd = 5'(rd);
      bus1.id_regdst = rdst; bus1.id_regwrite = rw; bus1.id_memread = mr; bus1.flush = fl;
    end
    e.d3 = d3; e.stall = e_stall; e.bub = e_bub; e.c_ex = c_ex; e.sel = e_sel;
    e.dest = 5'(e_dest); e.c_fwd = c_fwd; e.fa = e_fa; e.fb = e_fb;
    sb.push_back(e);
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    //   name         d3 rst v  rs  rt  rd dst rw mr fl  stl bub cex sel dst  cfw fa     fb
    cyc("reset",      0, 0, 0,  0,  0,  0, 0, 0, 0, 0,  0,  0,  1,  0,  0,  1, 2'b00, 2'b00);
    // DUT with LOAD_LAT=1
    cyc("t1_rtype",   0, 1, 1,  1,  2,  5, 1, 1, 0, 0,  0,  0,  1,  0,  0,  1, 2'b00, 2'b00);
    cyc("t1_itype",   0, 1, 1,  1,  7,  0, 0, 1, 0, 0,  0,  0,  1,  1,  5,  1, 2'b00, 2'b00);
    cyc("t1_idle",    0, 1, 0,  0,  0,  0, 0, 0, 0, 0,  0,  0,  1,  0,  7,  1, 2'b00, 2'b00);
    cyc("t2_lw8",     0, 1, 1,  1,  8,  0, 0, 1, 1, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("t2_use",     0, 1, 1,  8,  2,  9, 1, 1, 0, 0,  1,  0,  1,  0,  8,  1, 2'b00, 2'b00);
    cyc("t2_hold",    0, 1, 1,  8,  2,  9, 1, 1, 0, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("t4_add3",    0, 1, 1,  1,  2,  3, 1, 1, 0, 0,  0,  0,  1,  1,  9,  1, 2'b01, 2'b00);
    cyc("t4_sub",     0, 1, 1,  3,  3, 10, 1, 1, 0, 0,  0,  0,  1,  1,  3,  1, 2'b00, 2'b00);
    cyc("t4_add13",   0, 1, 1,  1,  2, 13, 1, 1, 0, 0,  0,  0,  1,  1, 10,  1, 2'b10, 2'b10);
    cyc("t4_fill",    0, 1, 1,  1,  2, 14, 1, 1, 0, 0,  0,  0,  1,  1, 13,  1, 2'b00, 2'b00);
    cyc("t4_use13",   0, 1, 1, 13, 13, 15, 1, 1, 0, 0,  0,  0,  1,  1, 14,  1, 2'b00, 2'b00);
    cyc("t5_idle",    0, 1, 0,  0,  0,  0, 0, 0, 0, 0,  0,  0,  1,  1, 15,  1, 2'b01, 2'b01);
    cyc("t5_lw0",     0, 1, 1,  1,  0,  0, 0, 1, 1, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("t5_use0",    0, 1, 1,  0,  0, 16, 1, 1, 0, 0,  0,  0,  1,  0,  0,  1, 2'b00, 2'b00);
    cyc("t5_lw2",     0, 1, 1,  1,  2,  0, 0, 1, 1, 0,  0,  0,  1,  1, 16,  1, 2'b00, 2'b00);
    cyc("t5_flush",   0, 1, 1,  2,  5, 17, 1, 1, 0, 1,  0,  0,  1,  0,  2,  1, 2'b00, 2'b00);
    cyc("t5_after",   0, 1, 0,  0,  0,  0, 0, 0, 0, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("nv_lw6",     0, 1, 1,  1,  6,  0, 0, 1, 1, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("nv_inv",     0, 1, 0,  6,  6,  0, 0, 0, 0, 0,  0,  0,  1,  0,  6,  1, 2'b00, 2'b00);
    cyc("nv_idle",    0, 1, 0,  0,  0,  0, 0, 0, 0, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    // DUT with LOAD_LAT=3
    cyc("t3_lw4",     1, 1, 1,  1,  4,  0, 0, 1, 1, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("t3_use",     1, 1, 1,  4,  2, 18, 1, 1, 0, 0,  1,  0,  1,  0,  4,  1, 2'b00, 2'b00);
    cyc("t3_st2",     1, 1, 1,  4,  2, 18, 1, 1, 0, 0,  1,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("t3_st3",     1, 1, 1,  4,  2, 18, 1, 1, 0, 0,  1,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("t3_go",      1, 1, 1,  4,  2, 18, 1, 1, 0, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("t3_ex",      1, 1, 0,  0,  0,  0, 0, 0, 0, 0,  0,  0,  1,  1, 18,  1, 2'b00, 2'b00);
    cyc("t6_lw4",     1, 1, 1,  1,  4,  0, 0, 1, 1, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("t6_use",     1, 1, 1,  4,  2, 19, 1, 1, 0, 0,  1,  0,  1,  0,  4,  1, 2'b00, 2'b00);
    cyc("t6_stall",   1, 1, 1,  4,  2, 19, 1, 1, 0, 0,  1,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    cyc("t6_rst",     1, 0, 1,  4,  2, 19, 1, 1, 0, 0,  0,  0,  1,  0,  0,  1, 2'b00, 2'b00);
    cyc("t6_rsthold", 1, 0, 0,  0,  0,  0, 0, 0, 0, 0,  0,  0,  1,  0,  0,  1, 2'b00, 2'b00);
    cyc("t6_resume",  1, 1, 1,  4,  2, 19, 1, 1, 0, 0,  0,  0,  1,  0,  0,  1, 2'b00, 2'b00);
    cyc("t6_ex",      1, 1, 0,  0,  0,  0, 0, 0, 0, 0,  0,  0,  1,  1, 19,  1, 2'b00, 2'b00);
    cyc("t6_idle",    1, 1, 0,  0,  0,  0, 0, 0, 0, 0,  0,  1,  0,  0,  0,  0, 2'b00, 2'b00);
    @(negedge clk);
    #1;
    chk("drain", "queued", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
